// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory byte-stream loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_word_pack.sv
// Assembles little-endian payload bytes into 32-bit words and pulses word_done
// for one cycle after the last lane of a word is accepted.
module imem_loader_word_pack
    import imem_loader_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        accept,
    input  logic [7:0]  data_byte,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_done,
    output logic        last_lane
);

    logic [LANE_W-1:0] cnt_q;
    logic [31:0]       word_q;
    logic              done_q;

    assign last_lane = (cnt_q == LANE_W'(BYTES_PER_WORD - 1));
    assign word      = word_q;
    assign word_done = done_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q  <= '0;
            word_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clear) begin
                cnt_q <= '0;
            end else if (accept) begin
                word_q[8*cnt_q +: 8] <= data_byte;
                cnt_q                <= cnt_q + 1'b1;
                done_q               <= last_lane;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Frame parser that writes a length-prefixed, XOR-checked program image into
// instruction memory and releases the core only after a verified load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_enable,
    output logic              load_done,
    output logic              load_error,
    output logic [15:0]       words_loaded
);

    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

    state_t            state;
    logic [15:0]       len_q;
    logic [ADDR_W:0]   word_idx;
    logic [7:0]        xor_q;

    logic              accept;
    logic              pack_accept;
    logic              pack_clear;
    logic              last_lane;
    logic [ADDR_W:0]   idx_next;
    logic [15:0]       hdr_len;

    assign accept      = in_valid & in_ready;
    assign pack_accept = accept && (state == S_DATA);
    assign pack_clear  = (state != S_DATA);
    assign idx_next    = word_idx + 1'b1;
    assign hdr_len     = {in_data, len_q[7:0]};
    assign cpu_enable  = load_done;

    imem_loader_word_pack u_word_pack (
        .Clk       (Clk),
        .Rst       (Rst),
        .accept    (pack_accept),
        .data_byte (in_data),
        .clear     (pack_clear),
        .word      (imem_wdata),
        .word_done (imem_we),
        .last_lane (last_lane)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= S_LEN_LO;
            in_ready     <= 1'b1;
            len_q        <= '0;
            word_idx     <= '0;
            xor_q        <= '0;
            imem_addr    <= '0;
            words_loaded <= '0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
        end else if (accept) begin
            case (state)
                S_LEN_LO: begin
                    len_q[7:0] <= in_data;
                    state      <= S_LEN_HI;
                end
                S_LEN_HI: begin
                    len_q[15:8] <= in_data;
                    // Oversize images are rejected here so word_idx can never wrap.
                    if ({1'b0, hdr_len} > MAX_WORDS) begin
                        state      <= S_ERROR;
                        in_ready   <= 1'b0;
                        load_error <= 1'b1;
                    end else if (hdr_len == 16'd0) begin
                        state <= S_CSUM;
                    end else begin
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    xor_q <= xor_q ^ in_data;
                    if (last_lane) begin
                        imem_addr    <= word_idx[ADDR_W-1:0];
                        word_idx     <= idx_next;
                        words_loaded <= 16'(idx_next);
                        if (16'(idx_next) == len_q) begin
                            state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    in_ready <= 1'b0;
                    if (in_data == xor_q) begin
                        state     <= S_DONE;
                        load_done <= 1'b1;
                    end else begin
                        state      <= S_ERROR;
                        load_error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random frames against a
// frame-level reference model of the expected writes and final status.
module tb_imem_loader;

    typedef logic [7:0] byte_q_t[$];

    logic        Clk = 1'b0;
    logic        Rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_enable;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_loaded;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  wq_addr[$];
    logic [31:0] wq_data[$];
    logic [15:0] wq_cnt[$];

    always #5 Clk = ~Clk;

    imem_loader #(.ADDR_W(8)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_enable   (cpu_enable),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    // Capture every write strobe away from the active edge.
    always @(negedge Clk) begin
        if (imem_we) begin
            wq_addr.push_back(imem_addr);
            wq_data.push_back(imem_wdata);
            wq_cnt.push_back(words_loaded);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        in_valid = 1'b0;
        @(negedge Clk);
        wq_addr.delete();
        wq_data.delete();
        wq_cnt.delete();
        Rst = 1'b0;
    endtask

    // Offer one byte, optionally after random idle cycles; returns at the negedge after transfer.
    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        bit ok = 1'b0;
        for (int g = 0; g < 4; g++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                @(negedge Clk);
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 50; t++) begin
            if (in_ready) begin
                @(negedge Clk);
                ok = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        in_valid = 1'b0;
        check("accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic load_frame(input int n, input byte_q_t payload, input bit corrupt,
                              input int gap_pct);
        logic [7:0]  csum = 8'h00;
        logic [31:0] w;
        bit          exp_ok;
        for (int i = 0; i < payload.size(); i++) csum ^= payload[i];
        if (corrupt) csum ^= 8'h01;
        exp_ok = (n <= 256) && !corrupt;

        send_byte(8'(n), gap_pct);
        send_byte(8'(n >> 8), gap_pct);
        if (n > 256) begin
            check("oversize_error", 64'(load_error), 64'd1);
            check("oversize_ready", 64'(in_ready), 64'd0);
            check("oversize_writes", 64'(wq_addr.size()), 64'd0);
            check("oversize_enable", 64'(cpu_enable), 64'd0);
            return;
        end
        for (int i = 0; i < payload.size(); i++) send_byte(payload[i], gap_pct);
        check("enable_before_csum", 64'(cpu_enable), 64'd0);
        send_byte(csum, gap_pct);
        check("load_done", 64'(load_done), 64'(exp_ok));
        check("load_error", 64'(load_error), 64'(!exp_ok));
        check("cpu_enable", 64'(cpu_enable), 64'(exp_ok));
        check("ready_after_csum", 64'(in_ready), 64'd0);
        check("write_count", 64'(wq_addr.size()), 64'(n));
        check("words_loaded", 64'(words_loaded), 64'(n));
        for (int k = 0; k < n && k < wq_addr.size(); k++) begin
            w = {payload[4*k+3], payload[4*k+2], payload[4*k+1], payload[4*k]};
            check("write_addr", 64'(wq_addr[k]), 64'(k % 256));
            check("write_data", 64'(wq_data[k]), 64'(w));
            check("write_cnt", 64'(wq_cnt[k]), 64'(k + 1));
        end
    endtask

    initial begin
        byte_q_t p;
        int n;
        int prev_writes;

        Rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (2) @(negedge Clk);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_we", 64'(imem_we), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        check("rst_wdata", 64'(imem_wdata), 64'd0);
        check("rst_enable", 64'(cpu_enable), 64'd0);
        check("rst_done", 64'(load_done), 64'd0);
        check("rst_error", 64'(load_error), 64'd0);
        check("rst_words", 64'(words_loaded), 64'd0);
        do_reset();

        // Two-instruction image, back-to-back
        p = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00};
        load_frame(2, p, 1'b0, 0);
        if (wq_data.size() == 2) begin
            check("word0_const", 64'(wq_data[0]), 64'h00A00513);
            check("word1_const", 64'(wq_data[1]), 64'h00500593);
        end else begin
            check("const_words_present", 64'(wq_data.size()), 64'd2);
        end

        // Bytes offered in a terminal state are dropped
        prev_writes = wq_addr.size();
        in_valid = 1'b1;
        in_data = 8'h5A;
        repeat (3) @(negedge Clk);
        in_valid = 1'b0;
        check("drop_writes", 64'(wq_addr.size()), 64'(prev_writes));
        check("drop_words", 64'(words_loaded), 64'd2);
        check("drop_done", 64'(load_done), 64'd1);

        do_reset();
        load_frame(2, p, 1'b1, 0);

        do_reset();
        p = {};
        load_frame(0, p, 1'b0, 0);

        do_reset();
        load_frame(257, p, 1'b0, 0);

        // Full-capacity image with random valid gaps
        do_reset();
        p = {};
        for (int i = 0; i < 1024; i++) p.push_back(8'($urandom_range(255)));
        load_frame(256, p, 1'b0, 30);
        if (wq_addr.size() == 256) check("last_addr", 64'(wq_addr[255]), 64'd255);

        // Reset part-way through word 0
        do_reset();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        Rst = 1'b1;
        @(negedge Clk);
        check("midrst_we", 64'(imem_we), 64'd0);
        check("midrst_words", 64'(words_loaded), 64'd0);
        check("midrst_writes", 64'(wq_addr.size()), 64'd0);
        check("midrst_ready", 64'(in_ready), 64'd1);
        Rst = 1'b0;
        p = {};
        for (int i = 0; i < 12; i++) p.push_back(8'($urandom_range(255)));
        load_frame(3, p, 1'b0, 0);

        // Reset from the done state
        Rst = 1'b1;
        @(negedge Clk);
        check("donerst_enable", 64'(cpu_enable), 64'd0);
        check("donerst_done", 64'(load_done), 64'd0);
        Rst = 1'b0;

        // Random frames
        for (int f = 0; f < 6; f++) begin
            do_reset();
            n = $urandom_range(1, 12);
            p = {};
            for (int i = 0; i < 4 * n; i++) p.push_back(8'($urandom_range(255)));
            load_frame(n, p, 1'($urandom_range(1)), 25);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that fills the instruction memory before the single-cycle core runs. It accepts a framed byte stream (length header, little-endian instruction words, XOR checksum) from a byte source such as a UART receiver. It writes each assembled word into the instruction memory write port and holds the core's `cpu_enable` low until the whole image is written and verified. It is the writer side of the instruction memory that the core's fetch path reads.

## Interface

- `ADDR_W`, 8, instruction memory word-address width; capacity is `2**ADDR_W` words.
- `Clk` input 1 — single clock, shared with the core.
- `Rst` input 1 — reset, synchronous, active-high.
- `in_valid` input 1 — byte available on `in_data`.
- `in_data` input 8 — stream byte.
- `in_ready` output 1 — loader accepts a byte. A byte transfers on a cycle with `in_valid & in_ready`.
- `imem_we` output 1 — one-cycle write strobe to instruction memory.
- `imem_addr` output ADDR_W — word address of the write; word index `k` maps to byte address `4k`.
- `imem_wdata` output 32 — assembled instruction word.
- `cpu_enable` output 1 — run enable to the PC register and register file.
- `load_done` output 1 — image loaded and checksum matched; sticky.
- `load_error` output 1 — oversize length or checksum mismatch; sticky.
- `words_loaded` output 16 — count of words written so far.

## Operation

- Frame format:
  - `LEN_LO`, `LEN_HI`: 16-bit word count N, little-endian.
  - Then 4·N payload bytes; each word is least-significant byte first.
  - Then one checksum byte, equal to the XOR of all 4·N payload bytes.
- States and transitions:
  - `S_LEN_LO` → `S_LEN_HI` on accept.
  - `S_LEN_HI` on accept:
    - N > 2**ADDR_W → `S_ERROR`.
    - N = 0 → `S_CSUM`.
    - Otherwise → `S_DATA`.
  - `S_DATA`: a 2-bit byte counter shifts each byte into a 32-bit register at lane [8·cnt +: 8]. On the 4th byte, it issues the write and increments the word index. After word N−1 → `S_CSUM`.
  - `S_CSUM` on accept:
    - byte equals running XOR → `S_DONE`.
    - otherwise → `S_ERROR`.
  - `S_DONE` and `S_ERROR` are terminal. Only `Rst` leaves them.
- The running XOR clears on reset and folds in every payload byte. Header bytes and the checksum byte are excluded.
- The word index is ADDR_W+1 bits internally and never wraps, because N ≤ 2**ADDR_W is enforced at `S_LEN_HI`. `imem_addr` is its low ADDR_W bits.
- `in_ready` is 1 in `S_LEN_LO`, `S_LEN_HI`, `S_DATA` and `S_CSUM`. It is 0 in `S_DONE` and `S_ERROR`; bytes offered there are dropped, with no side effects.
- `cpu_enable` = `load_done`. An error state never enables the core.

## Timing

- Reset values:
  - state = `S_LEN_LO`.
  - `in_ready` = 1 in the first cycle after reset.
  - `imem_we`, `imem_addr`, `imem_wdata`, `cpu_enable`, `load_done`, `load_error`, `words_loaded` all 0.
  - Byte counter, word index and XOR all 0.
- Write latency: `imem_we` is registered. It is high for exactly the one cycle after the 4th byte of a word is accepted, with `imem_addr` and `imem_wdata` valid in that same cycle.
- `words_loaded` increments in the same cycle as `imem_we`.
- Back-to-back bytes (in_valid held high every cycle) are accepted at one per cycle with no stall. The next word's first byte may be accepted during the previous word's `imem_we` cycle.
- `load_done` and `cpu_enable` rise one cycle after the checksum byte is accepted. `load_error` rises one cycle after the offending byte is accepted.
- `in_valid` may drop between any two bytes; state is held indefinitely, with no timeout.
- Reset mid-load: `Rst` asserted in any state returns everything to the reset values at the next `Clk` edge. Any pending `imem_we` is suppressed. Memory contents already written are not cleared.
- Simultaneous `Rst` and byte accept: reset wins and the byte is discarded.

## Structure

- Package `imem_loader_pkg`: state enum (`S_LEN_LO`, `S_LEN_HI`, `S_DATA`, `S_CSUM`, `S_DONE`, `S_ERROR`), `HDR_BYTES = 2`, `BYTES_PER_WORD = 4`.
- One sub-module, `imem_loader_word_pack`. It holds the byte counter, 32-bit shift/lane register and word-complete pulse, and takes `Clk`, `Rst`, accept, byte and clear.
- The top-level FSM, XOR, word index and output registers live in `imem_loader`.

## Test plan

- Bytes `02 00 13 05 A0 00 93 05 50 00 xx` (xx = XOR of the 8 payload bytes), sent back-to-back → `imem_we` at addr 0 with `00A00513`, then at addr 1 with `00500593`; `words_loaded` = 2; `cpu_enable` high one cycle after xx.
- Same frame with checksum xx^01 → both writes occur, `load_error` = 1, `cpu_enable` stays 0, `in_ready` = 0 afterwards.
- Header `00 00` then `00` → no `imem_we`, `load_done` = 1; header `01 01` with ADDR_W = 8 (N = 257) → `load_error` one cycle after the second byte, no writes.
- N = 256 with random gaps in `in_valid` → 256 writes, last at addr 255, no address wrap, `words_loaded` = 256, `load_done` = 1.
- `Rst` pulsed after 2 of 4 bytes of word 0 → no write; a fresh full frame then loads correctly from addr 0. `Rst` in `S_DONE` drops `cpu_enable` to 0 on the next edge.
